// File: rtl/sm_reg_display.sv
// -----------------------------------------------------------------------------
// sm_reg_display
//   Debug-port consumer for the CPU core's register-read port. Each frame
//   it presents a user-selected register address (0 = PC) on regAddr and
//   captures the returned regData into a 32-bit snapshot. The snapshot is
//   then shown as 8 hex digits on a common-anode (active-low) 7-segment
//   display, one digit at a time.
//
//   Frame: ADDR (1 cycle) -> CAPT (1 cycle) -> SCAN (8 * 2**REFRESH_DIV).
//   an/seg/dp are registered and lag digit/divcnt by one cycle.
//
//   Build option: define SM_DISPLAY_BLANK_EN for leading-zero blanking.
//   Digits above the most significant nonzero nibble are switched off, and
//   digit 0 is always lit. Scan timing is the same with or without it.
//
// Parameters
//   REFRESH_DIV  log2 of the number of cycles each digit is lit
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   selAddr  in   5   register to display (0 = PC), sampled in ADDR
//   freeze   in   1   1 = keep the current snapshot, sampled in CAPT
//   regAddr  out  5   debug register address to the core, held all frame
//   regData  in   32  debug register data, combinational from regAddr
//   an       out  8   digit enables, active-low, an[0] = least significant
//   seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp       out  1   decimal point, active-low (lit on digit 7 for PC)
// -----------------------------------------------------------------------------
module sm_reg_display #(
   parameter int REFRESH_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  selAddr,
   input  logic        freeze,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   typedef enum logic [1:0] {
      ADDR = 2'd0,
      CAPT = 2'd1,
      SCAN = 2'd2
   } state_t;

   localparam logic [REFRESH_DIV-1:0] DIV_ONE = {{(REFRESH_DIV-1){1'b0}}, 1'b1};

   state_t                 state;
   state_t                 next_state;
   logic [31:0]            snap;
   logic [2:0]             digit;
   logic [REFRESH_DIV-1:0] divcnt;

   logic [7:0]             an_next;
   logic [6:0]             seg_next;
   logic                   dp_next;
   logic [4:0]             nib_lsb;
   logic [3:0]             nib;
   logic                   lit;

   // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
   function automatic logic [6:0] hexseg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

`ifdef SM_DISPLAY_BLANK_EN
   // Index of the most significant nonzero nibble; 0 when the value is zero,
   // so digit 0 always stays lit.
   function automatic logic [2:0] top_digit(input logic [31:0] v);
      logic [2:0] m;
      m = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[4*i +: 4] != 4'h0) m = 3'(i);
      end
      return m;
   endfunction
`endif

   // Next-state and next-output logic
   always_comb begin
      next_state = state;
      an_next    = 8'hFF;
      seg_next   = 7'h7F;
      dp_next    = 1'b1;
      nib_lsb    = {digit, 2'b00};
      nib        = snap[nib_lsb +: 4];
`ifdef SM_DISPLAY_BLANK_EN
      lit        = (digit <= top_digit(snap));
`else
      lit        = 1'b1;
`endif
      case (state)
         ADDR: next_state = CAPT;
         CAPT: next_state = SCAN;
         SCAN: begin
            if ((digit == 3'd7) && (&divcnt)) next_state = ADDR;
            if (lit) begin
               an_next  = ~(8'h01 << digit);
               seg_next = hexseg(nib);
            end
            // dp follows the digit-7 slot even when that digit is blanked.
            dp_next = !((digit == 3'd7) && (regAddr == 5'd0));
         end
         default: next_state = ADDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ADDR;
      else     state <= next_state;
   end

   // Frame datapath and registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regAddr <= 5'd0;
         snap    <= 32'd0;
         digit   <= 3'd0;
         divcnt  <= '0;
         an      <= 8'hFF;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         case (state)
            ADDR: regAddr <= selAddr;
            CAPT: begin
               // regAddr changed on the previous edge, so regData is valid now.
               if (!freeze) snap <= regData;
               digit  <= 3'd0;
               divcnt <= '0;
            end
            SCAN: begin
               divcnt <= divcnt + DIV_ONE;
               if (&divcnt) digit <= digit + 3'd1;
            end
            default: ;
         endcase
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_sm_reg_display.sv
module tb_sm_reg_display;

   localparam int RD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  selAddr;
   logic        freeze;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   logic [31:0] rf [32];
   logic [6:0]  segtab [16];

   int checks = 0;
   int errors = 0;

   sm_reg_display #(.REFRESH_DIV(RD)) dut (
      .clk     (clk),
      .rst     (rst),
      .selAddr (selAddr),
      .freeze  (freeze),
      .regAddr (regAddr),
      .regData (regData),
      .an      (an),
      .seg     (seg),
      .dp      (dp)
   );

   // Register-file model of the core's debug port.
   assign regData = rf[regAddr];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // At most one digit enable low on any cycle outside reset.
   always @(negedge clk) begin
      if (rst === 1'b0) check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
   end

   // Runs one full frame, entered with the DUT in ADDR at a falling edge.
   task automatic run_frame(input logic [4:0] addr, input logic [31:0] data,
                            input int chg_i, input logic [4:0] chg_sel);
      int         top;
      int         d;
      logic [3:0] n;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      @(negedge clk);
      check("regAddr_latch", 32'(regAddr), 32'(addr));
      check("an_blank_capt", 32'(an), 32'hFF);
      @(negedge clk);
      check("an_blank_scan0", 32'(an), 32'hFF);
      check("seg_blank_scan0", 32'(seg), 32'h7F);
      top = 7;
`ifdef SM_DISPLAY_BLANK_EN
      top = 0;
      for (int k = 0; k < 8; k++) if (data[4*k +: 4] != 4'h0) top = k;
`endif
      for (int i = 0; i < 32; i++) begin
         if (i == chg_i) selAddr = chg_sel;
         @(negedge clk);
         d = i / 4;
         n = data[4*d +: 4];
         if (d > top) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
         end else begin
            exp_an  = 8'hFF ^ (8'h01 << d);
            exp_seg = segtab[n];
         end
         exp_dp = !((d == 7) && (addr == 5'd0));
         check("an", 32'(an), 32'(exp_an));
         check("seg", 32'(seg), 32'(exp_seg));
         check("dp", 32'(dp), 32'(exp_dp));
         check("regAddr_hold", 32'(regAddr), 32'(addr));
      end
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
      segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
      segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
      segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
      segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
      segtab[10] = 7'b0001000; segtab[11] = 7'b0000011;
      segtab[12] = 7'b1000110; segtab[13] = 7'b0100001;
      segtab[14] = 7'b0000110; segtab[15] = 7'b0001110;
      for (int k = 0; k < 32; k++) rf[k] = 32'h0;
      rf[0] = 32'h0000_00F0;
      rf[3] = 32'h0000_0001;
      rf[5] = 32'h0123_ABCD;
      rf[9] = 32'h4567_89EF;

      // Reset held with a nonzero selection
      rst     = 1'b1;
      selAddr = 5'd5;
      freeze  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_regAddr", 32'(regAddr), 32'd0);
      rst = 1'b0;

      // Register 5, selection changes to 9 mid-frame
      run_frame(5'd5, 32'h0123_ABCD, 8, 5'd9);
      run_frame(5'd9, 32'h4567_89EF, -1, 5'd0);

      // Freeze holds the snapshot across frames
      selAddr = 5'd3;
      run_frame(5'd3, 32'h0000_0001, -1, 5'd0);
      freeze = 1'b1;
      rf[3]  = 32'hFFFF_FFFF;
      run_frame(5'd3, 32'h0000_0001, -1, 5'd0);
      run_frame(5'd3, 32'h0000_0001, -1, 5'd0);
      freeze = 1'b0;
      run_frame(5'd3, 32'hFFFF_FFFF, -1, 5'd0);

      // PC view lights dp on digit 7
      selAddr = 5'd0;
      run_frame(5'd0, 32'h0000_00F0, -1, 5'd0);

      // Asynchronous reset pulse mid-SCAN, between clock edges
      selAddr = 5'd5;
      repeat (12) @(negedge clk);
      check("pre_rst_an_lit", 32'(an != 8'hFF), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_an", 32'(an), 32'hFF);
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_dp", 32'(dp), 32'd1);
      check("async_rst_regAddr", 32'(regAddr), 32'd0);
      #1 rst = 1'b0;
      run_frame(5'd5, 32'h0123_ABCD, -1, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
